// File: rtl/deserializer_if.sv
// Handshake bundle between the serial link, the deserializer and its parallel consumer.
// The slave modport is the deserializer side; the master modport is the driver/consumer side.
interface deserializer_if #(
   parameter int unsigned DATA_W = 16
);
   logic              ser_data;
   logic              ser_data_val;
   logic [DATA_W-1:0] deser_data;
   logic              deser_data_val;
   logic              deser_data_ready;
   logic              overflow;

   modport master (
      output ser_data, ser_data_val, deser_data_ready,
      input  deser_data, deser_data_val, overflow
   );

   modport slave (
      input  ser_data, ser_data_val, deser_data_ready,
      output deser_data, deser_data_val, overflow
   );
endinterface

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver with a 2-entry output buffer.
// The buffer is a head/tail register pair, so the head word drives the output straight from a flop.
module deserializer #(
   parameter int unsigned DATA_W = 16
) (
   input logic             clk_i,
   input logic             arst_n_i,
   deserializer_if.slave   bus_io
);

   localparam int unsigned CntW = $clog2(DATA_W);
   localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

   logic [DATA_W-2:0] shift_q, shift_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;
   logic [1:0]        count_q, count_d;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] word;
   logic              push;
   logic              pop;

   always_comb begin
      word      = {shift_q, bus_io.ser_data};
      push      = bus_io.ser_data_val && (bit_cnt_q == LastCnt);
      pop       = (count_q != 2'd0) && bus_io.deser_data_ready;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      ovf_d     = ovf_q;

      if (bus_io.ser_data_val) begin
         shift_d   = word[DATA_W-2:0];
         bit_cnt_d = push ? '0 : bit_cnt_q + 1'b1;
      end

      case ({push, pop})
         2'b11: begin
            // Simultaneous pop frees a slot, so a full buffer still accepts the word.
            if (count_q == 2'd2) begin
               head_d = tail_q;
               tail_d = word;
            end else begin
               head_d = word;
            end
         end
         2'b01: begin
            if (count_q == 2'd2) head_d = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b10: begin
            case (count_q)
               2'd0: begin
                  head_d  = word;
                  count_d = 2'd1;
               end
               2'd1: begin
                  tail_d  = word;
                  count_d = 2'd2;
               end
               default: ovf_d = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= 2'd0;
         ovf_q     <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus_io.deser_data     = head_q;
   assign bus_io.deser_data_val = (count_q != 2'd0);
   assign bus_io.overflow       = ovf_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: reset, basic/gapped words, backpressure, overflow,
// simultaneous push/pop at full, back-to-back words and reset mid-word.
module tb_deserializer;

   logic clk_i;
   logic arst_n_i;

   deserializer_if #(.DATA_W(16)) bus ();

   deserializer #(.DATA_W(16)) u_dut (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .bus_io   (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Sends one word MSB first; early flags a valid output seen before the last bit.
   task automatic send_word(input logic [15:0] w, input int unsigned gap_max,
                            input bit rdy_last, output bit early);
      early = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         bus.ser_data     = w[i];
         bus.ser_data_val = 1'b1;
         if (i == 0 && rdy_last) bus.deser_data_ready = 1'b1;
         tick();
         if (i == 0 && rdy_last) bus.deser_data_ready = 1'b0;
         if (i != 0 && bus.deser_data_val) early = 1'b1;
         if (i != 0 && gap_max > 0) begin
            bus.ser_data_val = 1'b0;
            bus.ser_data     = 1'bx;
            repeat ($urandom_range(gap_max, 0)) begin
               tick();
               if (bus.deser_data_val) early = 1'b1;
            end
         end
      end
      bus.ser_data_val = 1'b0;
      bus.ser_data     = 1'bx;
   endtask

   task automatic pulse_reset();
      #2 arst_n_i = 1'b0;
      #2 arst_n_i = 1'b1;
      tick();
   endtask

   bit early;

   initial begin
      arst_n_i             = 1'b0;
      bus.ser_data         = 1'b0;
      bus.ser_data_val     = 1'b0;
      bus.deser_data_ready = 1'b0;
      #1;
      check_eq("rst_data", 32'(bus.deser_data), 32'h0);
      check_eq("rst_val", 32'(bus.deser_data_val), 32'h0);
      check_eq("rst_ovf", 32'(bus.overflow), 32'h0);
      #21 arst_n_i = 1'b1;
      tick();

      // Basic word
      bus.deser_data_ready = 1'b1;
      send_word(16'hA5C3, 0, 1'b0, early);
      check_eq("basic_early", 32'(early), 32'h0);
      check_eq("basic_val", 32'(bus.deser_data_val), 32'h1);
      check_eq("basic_data", 32'(bus.deser_data), 32'hA5C3);
      check_eq("basic_ovf", 32'(bus.overflow), 32'h0);
      tick();
      check_eq("basic_val_off", 32'(bus.deser_data_val), 32'h0);

      // Gapped input
      send_word(16'h8001, 5, 1'b0, early);
      check_eq("gap_early", 32'(early), 32'h0);
      check_eq("gap_val", 32'(bus.deser_data_val), 32'h1);
      check_eq("gap_data", 32'(bus.deser_data), 32'h8001);
      tick();
      check_eq("gap_val_off", 32'(bus.deser_data_val), 32'h0);

      // Backpressure
      bus.deser_data_ready = 1'b0;
      send_word(16'h1234, 0, 1'b0, early);
      check_eq("bp_val1", 32'(bus.deser_data_val), 32'h1);
      check_eq("bp_data1", 32'(bus.deser_data), 32'h1234);
      send_word(16'hABCD, 0, 1'b0, early);
      check_eq("bp_val2", 32'(bus.deser_data_val), 32'h1);
      check_eq("bp_data2", 32'(bus.deser_data), 32'h1234);
      bus.deser_data_ready = 1'b1;
      tick();
      check_eq("bp_pop1_val", 32'(bus.deser_data_val), 32'h1);
      check_eq("bp_pop1_data", 32'(bus.deser_data), 32'hABCD);
      tick();
      check_eq("bp_empty", 32'(bus.deser_data_val), 32'h0);
      check_eq("bp_ovf", 32'(bus.overflow), 32'h0);

      // Overflow: third word dropped
      bus.deser_data_ready = 1'b0;
      send_word(16'h1234, 0, 1'b0, early);
      send_word(16'hABCD, 0, 1'b0, early);
      send_word(16'hFFFF, 0, 1'b0, early);
      check_eq("ovf_set", 32'(bus.overflow), 32'h1);
      check_eq("ovf_head", 32'(bus.deser_data), 32'h1234);
      repeat (3) tick();
      check_eq("ovf_sticky", 32'(bus.overflow), 32'h1);
      bus.deser_data_ready = 1'b1;
      tick();
      check_eq("ovf_drain2", 32'(bus.deser_data), 32'hABCD);
      check_eq("ovf_drain2_val", 32'(bus.deser_data_val), 32'h1);
      tick();
      check_eq("ovf_drained", 32'(bus.deser_data_val), 32'h0);
      check_eq("ovf_still", 32'(bus.overflow), 32'h1);

      // Push and pop together at full
      bus.deser_data_ready = 1'b0;
      pulse_reset();
      check_eq("pp_rst_ovf", 32'(bus.overflow), 32'h0);
      send_word(16'h1234, 0, 1'b0, early);
      send_word(16'hABCD, 0, 1'b0, early);
      send_word(16'hFFFF, 0, 1'b1, early);
      check_eq("pp_ovf", 32'(bus.overflow), 32'h0);
      check_eq("pp_head", 32'(bus.deser_data), 32'hABCD);
      check_eq("pp_val", 32'(bus.deser_data_val), 32'h1);
      bus.deser_data_ready = 1'b1;
      tick();
      check_eq("pp_second", 32'(bus.deser_data), 32'hFFFF);
      check_eq("pp_second_val", 32'(bus.deser_data_val), 32'h1);
      tick();
      check_eq("pp_empty", 32'(bus.deser_data_val), 32'h0);

      // Back-to-back words, pulses 16 cycles apart
      send_word(16'h0F0F, 0, 1'b0, early);
      check_eq("b2b_val1", 32'(bus.deser_data_val), 32'h1);
      check_eq("b2b_data1", 32'(bus.deser_data), 32'h0F0F);
      send_word(16'hF0F0, 0, 1'b0, early);
      check_eq("b2b_gap", 32'(early), 32'h0);
      check_eq("b2b_val2", 32'(bus.deser_data_val), 32'h1);
      check_eq("b2b_data2", 32'(bus.deser_data), 32'hF0F0);
      tick();
      check_eq("b2b_off", 32'(bus.deser_data_val), 32'h0);

      // Reset mid-word with a buffered word pending
      bus.deser_data_ready = 1'b0;
      send_word(16'h5555, 0, 1'b0, early);
      for (int i = 0; i < 7; i++) begin
         bus.ser_data     = 1'b1;
         bus.ser_data_val = 1'b1;
         tick();
      end
      #3 arst_n_i = 1'b0;
      #1;
      check_eq("mid_rst_data", 32'(bus.deser_data), 32'h0);
      check_eq("mid_rst_val", 32'(bus.deser_data_val), 32'h0);
      check_eq("mid_rst_ovf", 32'(bus.overflow), 32'h0);
      bus.ser_data_val = 1'b0;
      #2 arst_n_i = 1'b1;
      tick();
      bus.deser_data_ready = 1'b1;
      send_word(16'h8001, 0, 1'b0, early);
      check_eq("mid_early", 32'(early), 32'h0);
      check_eq("mid_val", 32'(bus.deser_data_val), 32'h1);
      check_eq("mid_data", 32'(bus.deser_data), 32'h8001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
